core_lsu: RTL and testbench

- Load/store unit directly downstream of the instruction decoder's preempt path.
- Accepts one memory request per issue: load, store, load indirect or store indirect.
- Runs the request against data memory, or against the stdin/stdout port when the address equals IO_ADDR.
- Writes load results back to the register file, then pulses done so the core releases the stall and clears the destination dirty bit.

---
 rtl/core_lsu.sv | 190 +++++++++++++++++++
 tb/tb_core_lsu.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// Load/store unit: runs one load/store per issue against data memory or the
// stdin/stdout port, writes loads back to the register file, then pulses done.
module core_lsu #(
  parameter logic [7:0] IO_ADDR = 8'hFF,
  parameter bit         IO_EN   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_en_i,
  input  logic        req_wen_i,
  input  logic        req_kind_i,
  input  logic [15:0] req_instr_i,
  input  logic [15:0] req_rt_val_i,
  input  logic [15:0] req_rd_val_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [3:0]  done_rd_o,
  output logic        mem_req_o,
  output logic        mem_wen_o,
  output logic [7:0]  mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i,
  input  logic        stdin_valid_i,
  input  logic [15:0] stdin_data_i,
  output logic        stdin_ready_o,
  output logic        stdout_valid_o,
  output logic [15:0] stdout_data_o,
  input  logic        stdout_ready_i,
  output logic        arf_wen_o,
  output logic [3:0]  arf_waddr_o,
  output logic [15:0] arf_wdata_o
);

  // state | meaning
  // IDLE  | waiting for a request
  // MEM   | memory request held until ack
  // IN    | waiting for a stdin word
  // OUT   | presenting a stdout word until accepted
  // WB    | completion cycle: done pulse, load writeback
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MEM  = 3'd1,
    S_IN   = 3'd2,
    S_OUT  = 3'd3,
    S_WB   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  rd_q, rd_d;
  logic        wen_q, wen_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  done_rd_q, done_rd_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wen_q, mem_wen_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        stdin_ready_q, stdin_ready_d;
  logic        stdout_valid_q, stdout_valid_d;
  logic [15:0] stdout_data_q, stdout_data_d;
  logic        arf_wen_q, arf_wen_d;
  logic [3:0]  arf_waddr_q, arf_waddr_d;
  logic [15:0] arf_wdata_q, arf_wdata_d;

  logic [7:0]  req_addr;
  logic        req_io;
  logic        unused_bits;

  assign unused_bits = ^{req_instr_i[15:12], req_rt_val_i[15:8]};

  assign req_addr = req_kind_i ? req_instr_i[7:0] : req_rt_val_i[7:0];
  assign req_io   = IO_EN && (req_addr == IO_ADDR);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (req_en_i) begin
          rd_d   = req_instr_i[11:8];
          wen_d  = req_wen_i;
          addr_d = req_addr;
          data_d = req_rd_val_i;
          if (req_io) state_d = req_wen_i ? S_OUT : S_IN;
          else        state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ack_i) begin
          if (!wen_q) data_d = mem_rdata_i;
          state_d = S_WB;
        end
      end
      S_IN: begin
        if (stdin_valid_i && stdin_ready_q) begin
          data_d  = stdin_data_i;
          state_d = S_WB;
        end
      end
      S_OUT: begin
        if (stdout_ready_i) state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered,
  // aligned with the state they describe.
  always_comb begin
    busy_d         = (state_d != S_IDLE);
    mem_req_d      = (state_d == S_MEM);
    mem_wen_d      = mem_req_d && wen_d;
    mem_addr_d     = mem_req_d ? addr_d : 8'h00;
    mem_wdata_d    = (mem_req_d && wen_d) ? data_d : 16'h0000;
    stdin_ready_d  = (state_d == S_IN);
    stdout_valid_d = (state_d == S_OUT);
    stdout_data_d  = stdout_valid_d ? data_d : 16'h0000;
    done_d         = (state_d == S_WB);
    done_rd_d      = done_d ? rd_d : 4'h0;
    arf_wen_d      = done_d && !wen_d && (rd_d != 4'h0);
    arf_waddr_d    = (done_d && !wen_d) ? rd_d : 4'h0;
    arf_wdata_d    = (done_d && !wen_d) ? data_d : 16'h0000;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      rd_q           <= 4'h0;
      wen_q          <= 1'b0;
      addr_q         <= 8'h00;
      data_q         <= 16'h0000;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      done_rd_q      <= 4'h0;
      mem_req_q      <= 1'b0;
      mem_wen_q      <= 1'b0;
      mem_addr_q     <= 8'h00;
      mem_wdata_q    <= 16'h0000;
      stdin_ready_q  <= 1'b0;
      stdout_valid_q <= 1'b0;
      stdout_data_q  <= 16'h0000;
      arf_wen_q      <= 1'b0;
      arf_waddr_q    <= 4'h0;
      arf_wdata_q    <= 16'h0000;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      wen_q          <= wen_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      done_rd_q      <= done_rd_d;
      mem_req_q      <= mem_req_d;
      mem_wen_q      <= mem_wen_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      stdin_ready_q  <= stdin_ready_d;
      stdout_valid_q <= stdout_valid_d;
      stdout_data_q  <= stdout_data_d;
      arf_wen_q      <= arf_wen_d;
      arf_waddr_q    <= arf_waddr_d;
      arf_wdata_q    <= arf_wdata_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign done_rd_o      = done_rd_q;
  assign mem_req_o      = mem_req_q;
  assign mem_wen_o      = mem_wen_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign stdin_ready_o  = stdin_ready_q;
  assign stdout_valid_o = stdout_valid_q;
  assign stdout_data_o  = stdout_data_q;
  assign arf_wen_o      = arf_wen_q;
  assign arf_waddr_o    = arf_waddr_q;
  assign arf_wdata_o    = arf_wdata_q;

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: randomized requests, behavioural memory and
// stdio responders, decoupled monitor comparing accesses and completions.
module tb_core_lsu;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_en_i = 1'b0, req_wen_i = 1'b0, req_kind_i = 1'b0;
  logic [15:0] req_instr_i = '0, req_rt_val_i = '0, req_rd_val_i = '0;
  logic        busy_o, done_o;
  logic [3:0]  done_rd_o;
  logic        mem_req_o, mem_wen_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_rdata_i = '0;
  logic        stdin_valid_i = 1'b0;
  logic [15:0] stdin_data_i = '0;
  logic        stdin_ready_o;
  logic        stdout_valid_o;
  logic [15:0] stdout_data_o;
  logic        stdout_ready_i = 1'b0;
  logic        arf_wen_o;
  logic [3:0]  arf_waddr_o;
  logic [15:0] arf_wdata_o;

  always #5 clk_i = ~clk_i;

  core_lsu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_en_i(req_en_i), .req_wen_i(req_wen_i), .req_kind_i(req_kind_i),
    .req_instr_i(req_instr_i), .req_rt_val_i(req_rt_val_i), .req_rd_val_i(req_rd_val_i),
    .busy_o(busy_o), .done_o(done_o), .done_rd_o(done_rd_o),
    .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stdin_valid_i(stdin_valid_i), .stdin_data_i(stdin_data_i), .stdin_ready_o(stdin_ready_o),
    .stdout_valid_o(stdout_valid_o), .stdout_data_o(stdout_data_o), .stdout_ready_i(stdout_ready_i),
    .arf_wen_o(arf_wen_o), .arf_waddr_o(arf_waddr_o), .arf_wdata_o(arf_wdata_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // kind: 0 memory, 1 stdin, 2 stdout
  typedef struct { int kind; logic [7:0] addr; logic wen; logic [15:0] wdata; } acc_t;
  typedef struct { logic [3:0] rd; logic load; logic [15:0] data; } cmp_t;

  acc_t        acc_q[$];
  cmp_t        exp_q[$];
  logic [15:0] stdin_q[$];
  logic [15:0] mem_arr[256];
  logic [15:0] ref_mem[256];

  int ack_delay = -1, in_delay = -1, out_delay = -1;
  bit hold_ack = 1'b0;

  // Memory responder
  int m_cnt = 0, m_tgt = 0;
  always @(negedge clk_i) begin
    if (mem_ack_i) begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      m_cnt       = 0;
    end else if (mem_req_o && !hold_ack) begin
      if (m_cnt == 0) m_tgt = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
      if (m_cnt >= m_tgt) begin
        mem_ack_i = 1'b1;
        if (mem_wen_o) mem_arr[mem_addr_o] = mem_wdata_o;
        else           mem_rdata_i = mem_arr[mem_addr_o];
      end else m_cnt++;
    end else m_cnt = 0;
  end

  // Stdin source
  int i_cnt = 0, i_tgt = 0;
  always @(negedge clk_i) begin
    if (stdin_valid_i) begin
      stdin_valid_i = 1'b0;
      stdin_data_i  = '0;
      void'(stdin_q.pop_front());
      i_cnt = 0;
    end else if (stdin_ready_o && stdin_q.size() > 0) begin
      if (i_cnt == 0) i_tgt = (in_delay < 0) ? int'($urandom_range(0, 4)) : in_delay;
      if (i_cnt >= i_tgt) begin
        stdin_valid_i = 1'b1;
        stdin_data_i  = stdin_q[0];
      end else i_cnt++;
    end else i_cnt = 0;
  end

  // Stdout sink
  int o_cnt = 0, o_tgt = 0;
  always @(negedge clk_i) begin
    if (stdout_ready_i) begin
      stdout_ready_i = 1'b0;
      o_cnt = 0;
    end else if (stdout_valid_o) begin
      if (o_cnt == 0) o_tgt = (out_delay < 0) ? int'($urandom_range(0, 4)) : out_delay;
      if (o_cnt >= o_tgt) stdout_ready_i = 1'b1;
      else o_cnt++;
    end else o_cnt = 0;
  end

  // Monitor: handshakes seen at an edge must produce done in the next cycle
  bit   hs_seen = 1'b0;
  bit   p_mreq = 1'b0, p_inr = 1'b0, p_outv = 1'b0;
  acc_t cur;

  always @(posedge clk_i) begin
    hs_seen = !rst_i && ((mem_req_o && mem_ack_i) || (stdin_valid_i && stdin_ready_o) ||
                         (stdout_valid_o && stdout_ready_i));
    if (req_en_i) check("req_while_busy", 32'(busy_o), 32'd0);
  end

  task automatic new_access(input int kind);
    if (acc_q.size() == 0) check("unexpected_access", 32'(kind), 32'hFFFF_FFFF);
    else begin
      cur = acc_q.pop_front();
      check("access_kind", 32'(kind), 32'(cur.kind));
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o || hs_seen) check("done_timing", 32'(done_o), 32'(hs_seen));
      if (done_o) begin
        if (exp_q.size() == 0) check("done_without_request", 32'(exp_q.size()), 32'd1);
        else begin
          cmp_t e;
          e = exp_q.pop_front();
          check("done_rd", 32'(done_rd_o), 32'(e.rd));
          check("arf_wen", 32'(arf_wen_o), 32'(e.load && (e.rd != 4'h0)));
          if (e.load) begin
            check("arf_waddr", 32'(arf_waddr_o), 32'(e.rd));
            check("arf_wdata", 32'(arf_wdata_o), 32'(e.data));
          end
        end
      end else begin
        check("quiet_outputs", {4'h0, done_rd_o, 3'h0, arf_wen_o, arf_waddr_o, arf_wdata_o}, 32'd0);
      end
      if (mem_req_o && !p_mreq)      new_access(0);
      if (stdin_ready_o && !p_inr)   new_access(1);
      if (stdout_valid_o && !p_outv) new_access(2);
      if (mem_req_o) begin
        check("mem_addr", 32'(mem_addr_o), 32'(cur.addr));
        check("mem_wen", 32'(mem_wen_o), 32'(cur.wen));
        if (cur.wen) check("mem_wdata", 32'(mem_wdata_o), 32'(cur.wdata));
      end
      if (stdout_valid_o) check("stdout_data", 32'(stdout_data_o), 32'(cur.wdata));
      if (stdin_ready_o || stdout_valid_o) check("io_no_mem", 32'(mem_req_o), 32'd0);
    end
    p_mreq = mem_req_o;
    p_inr  = stdin_ready_o;
    p_outv = stdout_valid_o;
  end

  // Reference model: address selection, IO routing and memory contents.
  task automatic issue(input logic wen, input logic kind, input logic [15:0] instr,
                       input logic [15:0] rt, input logic [15:0] rdv,
                       input logic [15:0] in_word, input bit complete);
    logic [7:0] a;
    bit         io;
    acc_t       ac;
    cmp_t       cp;
    a  = kind ? instr[7:0] : rt[7:0];
    io = (a == 8'hFF);
    ac.kind  = io ? (wen ? 2 : 1) : 0;
    ac.addr  = a;
    ac.wen   = wen;
    ac.wdata = rdv;
    acc_q.push_back(ac);
    if (complete) begin
      cp.rd   = instr[11:8];
      cp.load = !wen;
      cp.data = 16'h0000;
      if (!wen) begin
        if (io) begin
          stdin_q.push_back(in_word);
          cp.data = in_word;
        end else cp.data = ref_mem[a];
      end else if (!io) ref_mem[a] = rdv;
      exp_q.push_back(cp);
    end
    req_wen_i = wen; req_kind_i = kind; req_instr_i = instr;
    req_rt_val_i = rt; req_rd_val_i = rdv; req_en_i = 1'b1;
    @(negedge clk_i);
    req_en_i = 1'b0;
    req_instr_i = 16'($urandom); req_rt_val_i = 16'($urandom); req_rd_val_i = 16'($urandom);
    check("busy_after_accept", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (!busy_o) return;
    end
    check("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 16'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h10] = 16'h1234;
    ref_mem[8'h10] = 16'h1234;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", {done_o, done_rd_o, arf_wen_o, arf_waddr_o, arf_wdata_o}, 32'd0);
    check("rst_mem", {mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o}, 32'd0);
    check("rst_io", {stdin_ready_o, stdout_valid_o, stdout_data_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    ack_delay = 2;
    issue(1'b0, 1'b1, 16'h8A10, 16'h0000, 16'h0000, 16'h0000, 1);
    wait_idle();
    ack_delay = -1;
    issue(1'b1, 1'b0, 16'hB305, 16'hFF12, 16'hBEEF, 16'h0000, 1);
    wait_idle();
    check("store_mem", 32'(mem_arr[8'h12]), 32'h0000_BEEF);
    in_delay = 5;
    issue(1'b0, 1'b1, 16'h81FF, 16'h0000, 16'h0000, 16'h0042, 1);
    wait_idle();
    in_delay = -1;
    out_delay = 3;
    issue(1'b1, 1'b1, 16'h93FF, 16'h0000, 16'h0007, 16'h0000, 1);
    wait_idle();
    out_delay = -1;
    mem_arr[8'h10] = 16'h5555;
    ref_mem[8'h10] = 16'h5555;
    issue(1'b0, 1'b1, 16'h8010, 16'h0000, 16'h0000, 16'h0000, 1);
    wait_idle();

    // Abort a load while memory withholds its ack
    hold_ack = 1'b1;
    issue(1'b0, 1'b1, 16'h8C20, 16'h0000, 16'h0000, 16'h0000, 0);
    for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_mem_req", 32'(mem_req_o), 32'd0);
    check("abort_done", {done_o, arf_wen_o}, 32'd0);
    hold_ack = 1'b0;
    @(negedge clk_i);
    issue(1'b0, 1'b1, 16'h8C20, 16'h0000, 16'h0000, 16'h0000, 1);
    wait_idle();

    for (int n = 0; n < 150; n++) begin
      logic [7:0]  a;
      logic        w, k;
      logic [15:0] ins, rt;
      a   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      w   = 1'($urandom);
      k   = 1'($urandom);
      ins = 16'($urandom);
      rt  = 16'($urandom);
      if (k) ins[7:0] = a;
      else   rt[7:0]  = a;
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      issue(w, k, ins, rt, 16'($urandom), 16'($urandom), 1);
      wait_idle();
    end

    repeat (4) @(negedge clk_i);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("acc_q_drained", 32'(acc_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
